// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage feeding an external 32-bit 2:1 next-PC mux.
//
// The block holds the PC register and produces both mux data inputs:
// PC_PLUS4 goes to in0 and TARGET goes to in1. It also produces the mux
// select, TAKEN. The mux result comes back on NEXT_PC and is loaded on the
// next rising edge.
//
// A memory stall (BUSYWAIT) freezes the PC. If a redirect is seen while
// stalled, its target is captured and applied when the stall clears. Only
// the first redirect captured during a stall is kept.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      asynchronous active-high reset
//   BUSYWAIT   memory stall; PC holds while high
//   JUMP       unconditional redirect for the current instruction
//   BRANCH     conditional redirect (beq), qualified by ZERO
//   ZERO       ALU zero flag
//   OFFSET     signed word offset of the current instruction
//   NEXT_PC    selected next PC returned from the external mux
//   PC         current PC (registered)
//   PC_PLUS4   PC + 4, drives mux in0
//   TARGET     PC_PLUS4 + sext(OFFSET)*4, drives mux in1
//   TAKEN      mux select; 1 selects TARGET
//   PENDING    a redirect was latched during a stall and is not yet applied
//   state_dbg  raw FSM state (0 = RUN, 1 = HELD)
//
// Handshake: there is no valid/ready pair. BUSYWAIT acts as a stall
// qualifier: the PC advances at an edge only when BUSYWAIT is low at that
// edge, and a redirect is accepted into the latch only at an edge where
// BUSYWAIT is high, TAKEN is high and nothing is pending yet.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               OFF_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             ZERO,
  input  logic [OFF_W-1:0] OFFSET,
  input  logic [WIDTH-1:0] NEXT_PC,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic [WIDTH-1:0] TARGET,
  output logic             TAKEN,
  output logic             PENDING,
  output logic             state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic [WIDTH-1:0] latch_q, latch_nxt;
  logic [WIDTH-1:0] offset_bytes;

  // Sign-extend the word offset and scale it to bytes (two zero LSBs).
  assign offset_bytes = {{(WIDTH-OFF_W-2){OFFSET[OFF_W-1]}}, OFFSET, 2'b00};

  // Datapath: both mux inputs and the select are purely combinational.
  // They wrap modulo 2^WIDTH through plain unsigned addition.
  assign PC_PLUS4 = pc_q + WIDTH'(4);
  assign TARGET   = PC_PLUS4 + offset_bytes;
  // JUMP overrides the branch condition, so ZERO does not matter when JUMP=1.
  assign TAKEN    = JUMP | (BRANCH & ZERO);
  assign PC       = pc_q;

  // State register, PC register and redirect latch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RUN;
      pc_q    <= RESET_ADDR;
      latch_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      latch_q <= latch_nxt;
    end
  end

  // Next-state and next-PC logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    latch_nxt = latch_q;
    case (state)
      RUN: begin
        if (!BUSYWAIT) begin
          pc_nxt = NEXT_PC;
        end else if (TAKEN) begin
          // Stalled with a redirect: remember where to go once released.
          latch_nxt = TARGET;
          state_nxt = HELD;
        end
      end
      HELD: begin
        // While held, later redirects are ignored. On release, the external
        // mux output is stale, so the captured target is used instead.
        if (!BUSYWAIT) begin
          pc_nxt    = latch_q;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Moore outputs.
  always_comb begin
    PENDING   = 1'b0;
    state_dbg = 1'b0;
    PENDING   = (state == HELD);
    state_dbg = state;
  end

endmodule
